param_register_file: RTL

- Parametrised successor to the pipeline's general-purpose register file: configurable data width, depth and number of read ports, one write port.
- All state updates occur on the rising clock edge.
- An optional write-through bypass makes a same-cycle write visible to the reads, so ID-stage reads need no half-cycle write timing.
- A reset-time init sequencer loads each entry with its own index, one entry per cycle, and reports busy until done.
- Sits between the ID stage (read addresses) and the WB stage (write-back).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_init_seq.sv | 67 ++++++
 rtl/param_register_file.sv | 115 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file.
//   rf_state_e         : init sequencer states (INIT fills the array, READY is normal use)
//   RF_PC_INDEX        : architectural index of R15/PC, which is not held in the array
//   rf_default_addr_w  : address width needed to index a given depth
package regfile_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } rf_state_e;

   localparam int RF_PC_INDEX = 15;

   function automatic int rf_default_addr_w(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Reset-time init sequencer: after reset release, writes entry[i] = i for
// i = 0 .. DEPTH-1, one entry per clock edge, then moves to READY.
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       synchronous active-low reset
//   init_busy_o  high while in INIT (including while reset is held)
//   init_we_o    init write strobe into the array
//   init_addr_o  entry being initialised
//   init_data_o  zero-extended index written into that entry
//   state_o      current FSM state, for observation
module regfile_init_seq
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 15,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   output logic              init_busy_o,
   output logic              init_we_o,
   output logic [ADDR_W-1:0] init_addr_o,
   output logic [DATA_W-1:0] init_data_o,
   output rf_state_e         state_o
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   rf_state_e         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: the last entry is written on the same edge that leaves INIT,
   // so busy spans exactly DEPTH edges after reset release.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         if (cnt_q == LAST_IDX) begin
            state_d = READY;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Outputs: no init write on an edge where reset is asserted.
   always_comb begin
      init_busy_o = (state_q == INIT);
      init_we_o   = (state_q == INIT) && rst_ni;
      init_addr_o = cnt_q;
      init_data_o = DATA_W'(cnt_q);
      state_o     = state_q;
   end

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: DEPTH entries of DATA_W bits, NUM_RD
// combinational read ports, one write-back port, optional write-through
// bypass, and a reset-time init sequencer that loads entry[i] = i.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   rd_addr    packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    packed read data, port k at [k*DATA_W +: DATA_W]; 0 during INIT
//   wr_en      write-back enable (ignored during INIT)
//   wr_addr    write-back destination; >= DEPTH is dropped
//   wr_data    write-back value
//   init_busy  high while the init sequencer runs
module param_register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 15,
   parameter int ADDR_W = rf_default_addr_w(DEPTH),
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   output logic                     init_busy
);

   if (DATA_W < ADDR_W) begin : g_chk_width
      $error("param_register_file: DATA_W must be >= ADDR_W");
   end
   if ((2 ** ADDR_W) < DEPTH) begin : g_chk_addr
      $error("param_register_file: ADDR_W too small for DEPTH");
   end

   // Depth held one bit wider than an address so that 2**ADDR_W == DEPTH also works.
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_V);
   endfunction

   logic              init_we;
   logic [ADDR_W-1:0] init_addr;
   logic [DATA_W-1:0] init_data;
   rf_state_e         seq_state;
   logic              ready;

   regfile_init_seq #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_init_seq (
      .clk_i       (clk),
      .rst_ni      (rst),
      .init_busy_o (init_busy),
      .init_we_o   (init_we),
      .init_addr_o (init_addr),
      .init_data_o (init_data),
      .state_o     (seq_state)
   );

   assign ready = (seq_state == READY);

   // A write-back that actually lands this cycle (and may be forwarded).
   logic wb_fire;
   assign wb_fire = ready && wr_en && in_range(wr_addr);

   // Write arbitration: reset drops everything, INIT owns the port, else write-back.
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = init_addr;
      mem_wdata = init_data;
      if (rst) begin
         if (init_we) begin
            mem_we = 1'b1;
         end else if (wb_fire) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
         end
      end
   end

   // Storage is deliberately not reset; the init sequencer fills it.
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] stored;

      assign ra     = rd_addr[k*ADDR_W +: ADDR_W];
      assign stored = (ready && in_range(ra)) ? mem_q[ra] : '0;

      if (BYPASS != 0) begin : g_byp
         assign rd_data[k*DATA_W +: DATA_W] = (wb_fire && (ra == wr_addr)) ? wr_data : stored;
      end else begin : g_nobyp
         assign rd_data[k*DATA_W +: DATA_W] = stored;
      end
   end

endmodule
